// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_scoreboard
// Description : Multi-port GPR file with write-through bypass and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam int c_CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]  regs_q [c_DEPTH];
    logic [DATA_W-1:0]  regs_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;
    logic [c_CNT_W-1:0] busy_cnt_q;
    logic [c_CNT_W-1:0] busy_cnt_d;

    logic w_wr0_ok;
    logic w_wr1_ok;
    logic w_claim_ok;
    logic w_inc;
    logic w_dec0;
    logic w_dec1;

    assign w_wr0_ok   = wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
    assign w_wr1_ok   = wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
    assign w_claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

    // Count deltas are derived from the old busy vector: a set needs a clear bit,
    // a release needs a set bit, so both can never hit the same register.
    assign w_inc  = w_claim_ok && !busy_q[claim_addr];
    assign w_dec0 = wr0_en && busy_q[wr0_addr]
                    && !(w_claim_ok && (claim_addr == wr0_addr));
    assign w_dec1 = wr1_en && busy_q[wr1_addr]
                    && !(w_claim_ok && (claim_addr == wr1_addr))
                    && !(wr0_en && (wr0_addr == wr1_addr));

    always_comb begin
        regs_d = regs_q;
        if (w_wr0_ok) regs_d[wr0_addr] = wr0_data;
        if (w_wr1_ok) regs_d[wr1_addr] = wr1_data;
    end

    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q + c_CNT_W'(w_inc) - c_CNT_W'(w_dec0) - c_CNT_W'(w_dec1);
        if (wr0_en) busy_d[wr0_addr] = 1'b0;
        if (wr1_en) busy_d[wr1_addr] = 1'b0;
        if (w_claim_ok) busy_d[claim_addr] = 1'b1;
        if (flush) begin
            busy_d     = '0;
            busy_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_rel;

            assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
            assign w_rel  = (wr0_en && (wr0_addr == w_addr)) ||
                            (wr1_en && (wr1_addr == w_addr));

            // Later assignments take priority: zero reg, then wr1, then wr0.
            always_comb begin
                w_data = regs_q[w_addr];
                if (wr0_en && (wr0_addr == w_addr)) w_data = wr0_data;
                if (wr1_en && (wr1_addr == w_addr)) w_data = wr1_data;
                if ((ZERO_REG != 0) && (w_addr == '0)) w_data = '0;
            end

            assign rd_data[k*DATA_W +: DATA_W] = w_data;
            assign rd_busy[k] = busy_q[w_addr] & ~w_rel;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_scoreboard
// Description : Directed self-checking bench for regfile_mp_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_scoreboard;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_mp_scoreboard #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic claim(input logic [4:0] a);
        claim_en = 1'b1; claim_addr = a;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // 1: reset state on every register, both ports
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            #1;
            chk_eq("rst_rd0", rd_data[31:0], 32'h0);
            chk_eq("rst_rd1", rd_data[63:32], 32'h0);
            chk_eq("rst_busy", {30'h0, rd_busy}, 32'h0);
        end
        chk_eq("rst_cnt", {26'h0, busy_cnt}, 32'h0);
        rst = 1'b0;
        tick();

        // 2: write then read, and same-cycle bypass
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        #1;
        chk_eq("byp_wr0", rd_data[31:0], 32'hDEADBEEF);
        chk_eq("byp_other", rd_data[63:32], 32'h0);
        tick();
        idle();
        #1;
        chk_eq("stored_r5", rd_data[31:0], 32'hDEADBEEF);

        // 3: dual write same address, port 1 wins; r0 stays zero
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        set_rd(5'd0, 5'd7);
        #1;
        chk_eq("byp_wr1_wins", rd_data[63:32], 32'h22);
        tick();
        idle();
        #1;
        chk_eq("stored_r7", rd_data[63:32], 32'h22);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF;
        #1;
        chk_eq("r0_byp", rd_data[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk_eq("r0_stored", rd_data[31:0], 32'h0);

        // 4: claim then release with bypass
        claim(5'd3);
        set_rd(5'd3, 5'd5);
        #1;
        chk_eq("claim_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk_eq("claim_cnt", {26'h0, busy_cnt}, 32'h1);
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h55;
        #1;
        chk_eq("rel_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk_eq("rel_data", rd_data[31:0], 32'h55);
        tick();
        idle();
        #1;
        chk_eq("rel_cnt", {26'h0, busy_cnt}, 32'h0);
        chk_eq("rel_busy_after", {31'h0, rd_busy[0]}, 32'h0);

        // 5: claim and write same register same cycle -> claim wins
        claim_en = 1'b1; claim_addr = 5'd4;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hAB;
        tick();
        idle();
        set_rd(5'd4, 5'd0);
        #1;
        chk_eq("cw_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk_eq("cw_cnt", {26'h0, busy_cnt}, 32'h1);
        chk_eq("cw_data", rd_data[31:0], 32'hAB);
        chk_eq("r0_notbusy", {31'h0, rd_busy[1]}, 32'h0);
        claim(5'd0);
        chk_eq("claim_r0_cnt", {26'h0, busy_cnt}, 32'h1);
        claim(5'd4);
        chk_eq("reclaim_cnt", {26'h0, busy_cnt}, 32'h1);

        // dual release of two distinct busy registers in one cycle
        claim(5'd20);
        claim(5'd21);
        chk_eq("two_claim_cnt", {26'h0, busy_cnt}, 32'h3);
        wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'h20;
        wr1_en = 1'b1; wr1_addr = 5'd21; wr1_data = 32'h21;
        tick();
        idle();
        set_rd(5'd20, 5'd21);
        #1;
        chk_eq("dual_rel_cnt", {26'h0, busy_cnt}, 32'h1);
        chk_eq("dual_rel_busy", {30'h0, rd_busy}, 32'h0);
        chk_eq("dual_rel_d0", rd_data[31:0], 32'h20);
        chk_eq("dual_rel_d1", rd_data[63:32], 32'h21);

        // 6: claims, then flush with simultaneous claim and write
        claim(5'd1);
        claim(5'd2);
        claim(5'd9);
        chk_eq("pre_flush_cnt", {26'h0, busy_cnt}, 32'h4);
        flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd10;
        wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'h77;
        tick();
        idle();
        #1;
        chk_eq("flush_cnt", {26'h0, busy_cnt}, 32'h0);
        set_rd(5'd1, 5'd2);
        #1;
        chk_eq("flush_busy_a", {30'h0, rd_busy}, 32'h0);
        set_rd(5'd9, 5'd10);
        #1;
        chk_eq("flush_busy_b", {30'h0, rd_busy}, 32'h0);
        set_rd(5'd11, 5'd4);
        #1;
        chk_eq("flush_wr", rd_data[31:0], 32'h77);
        chk_eq("flush_busy_c", {30'h0, rd_busy}, 32'h0);

        // asynchronous reset mid-sequence
        claim(5'd12);
        chk_eq("pre_rst_cnt", {26'h0, busy_cnt}, 32'h1);
        set_rd(5'd5, 5'd12);
        rst = 1'b1;
        #1;
        chk_eq("arst_cnt", {26'h0, busy_cnt}, 32'h0);
        chk_eq("arst_r5", rd_data[31:0], 32'h0);
        chk_eq("arst_busy", {30'h0, rd_busy}, 32'h0);
        claim_en = 1'b1; claim_addr = 5'd13;
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h99;
        tick();
        idle();
        rst = 1'b0;
        tick();
        set_rd(5'd13, 5'd11);
        #1;
        chk_eq("arst_abort_wr", rd_data[31:0], 32'h0);
        chk_eq("arst_abort_r11", rd_data[63:32], 32'h0);
        chk_eq("arst_abort_cnt", {26'h0, busy_cnt}, 32'h0);
        chk_eq("arst_abort_busy", {30'h0, rd_busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
